// File: rtl/banyan_trig_pkg.sv
// Shared state encoding for the banyan capture-trigger sequencer.
// The localparam codes mirror the status register field read by the host.
package banyan_trig_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_DELAY = 2'd2,
    ST_RUN   = 2'd3
  } trig_state_t;

  localparam logic [1:0] STATE_CODE_IDLE  = 2'd0;
  localparam logic [1:0] STATE_CODE_ARMED = 2'd1;
  localparam logic [1:0] STATE_CODE_DELAY = 2'd2;
  localparam logic [1:0] STATE_CODE_RUN   = 2'd3;

endpackage

// File: rtl/trig_sync_edge.sv
// Two-flop synchronizer for the asynchronous trigger pin followed by a
// rising-edge detector; edge_o is a single adc_clk-cycle pulse.
module trig_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic sig_i,
  output logic edge_o
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= sig_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign edge_o = sync_q & ~prev_q;

endmodule

// File: rtl/banyan_trig_ctl.sv
// Arm / external-trigger / delay / run sequencer driving banyan_mem reset and run.
// Every entry into RUN (including force restarts) emits one mem_reset pulse.
module banyan_trig_ctl
  import banyan_trig_pkg::*;
#(
  parameter int dw_delay = 16,
  parameter int dw_count = 16
) (
  input  logic                adc_clk,
  input  logic                rst,
  input  logic                force_i,
  input  logic                arm_i,
  input  logic                disarm_i,
  input  logic                ext_trig_en_i,
  input  logic                ext_trig_i,
  input  logic [dw_delay-1:0] trig_delay_i,
  input  logic                data_valid_i,
  input  logic                rollover_i,
  output logic                mem_reset_o,
  output logic                mem_run_o,
  output logic                run_s_o,
  output logic [1:0]          state_o,
  output logic                done_o,
  output logic [dw_count-1:0] trig_count_o
);

  trig_state_t         state_q, state_d;
  logic [dw_delay-1:0] dly_q, dly_d;
  logic [dw_count-1:0] trig_count_q, trig_count_d;
  logic                mem_reset_q;
  logic                mem_run_q, mem_run_d;
  logic                run_s_q;
  logic                done_q, done_d;
  logic                enter_run;
  logic                set_done;
  logic                clr_done;
  logic                ext_edge;

  // data_valid gating of run happens inside banyan_mem; it is not used here.
  logic unused_data_valid;
  assign unused_data_valid = data_valid_i;

  trig_sync_edge u_sync (
    .clk    (adc_clk),
    .rst    (rst),
    .sig_i  (ext_trig_i),
    .edge_o (ext_edge)
  );

  // Event priority: force > disarm > rollover > ext edge / delay expiry > arm.
  always_comb begin
    state_d   = state_q;
    dly_d     = dly_q;
    enter_run = 1'b0;
    set_done  = 1'b0;
    clr_done  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (force_i) begin
          enter_run = 1'b1;
        end else if (arm_i) begin
          clr_done = 1'b1;
          if (ext_trig_en_i) state_d = ST_ARMED;
          else               enter_run = 1'b1;
        end
      end
      ST_ARMED: begin
        if (force_i) begin
          enter_run = 1'b1;
        end else if (disarm_i) begin
          state_d = ST_IDLE;
        end else if (ext_edge) begin
          if (trig_delay_i == '0) begin
            enter_run = 1'b1;
          end else begin
            dly_d   = trig_delay_i;
            state_d = ST_DELAY;
          end
        end
      end
      ST_DELAY: begin
        if (force_i)                           enter_run = 1'b1;
        else if (disarm_i)                     state_d   = ST_IDLE;
        else if (dly_q <= dw_delay'(1))        enter_run = 1'b1;
        else                                   dly_d     = dly_q - dw_delay'(1);
      end
      ST_RUN: begin
        if (force_i) begin
          enter_run = 1'b1;
        end else if (disarm_i) begin
          state_d = ST_IDLE;
        end else if (rollover_i) begin
          state_d  = ST_IDLE;
          set_done = 1'b1;
        end
      end
    endcase

    if (enter_run) state_d = ST_RUN;
  end

  // run is withheld during the reset pulse cycle so each fill starts clean.
  assign mem_run_d    = (state_d == ST_RUN) && !enter_run;
  assign trig_count_d = enter_run ? trig_count_q + dw_count'(1) : trig_count_q;
  assign done_d       = set_done ? 1'b1 : ((enter_run || clr_done) ? 1'b0 : done_q);

  always_ff @(posedge adc_clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      mem_reset_q  <= 1'b0;
      mem_run_q    <= 1'b0;
      run_s_q      <= 1'b0;
      done_q       <= 1'b0;
      trig_count_q <= '0;
    end else begin
      state_q      <= state_d;
      mem_reset_q  <= enter_run;
      mem_run_q    <= mem_run_d;
      run_s_q      <= mem_run_d | mem_run_q;
      done_q       <= done_d;
      trig_count_q <= trig_count_d;
    end
  end

  // The delay counter is only meaningful in DELAY, where it is always loaded first.
  always_ff @(posedge adc_clk) begin
    dly_q <= dly_d;
  end

  assign mem_reset_o  = mem_reset_q;
  assign mem_run_o    = mem_run_q;
  assign run_s_o      = run_s_q;
  assign state_o      = state_q;
  assign done_o       = done_q;
  assign trig_count_o = trig_count_q;

endmodule

// File: tb/tb_banyan_trig_ctl.sv
// Directed bench for banyan_trig_ctl: a cycle-by-cycle vector table plus
// hand-written sequences for delay, coincident events, reset and wrap.
module tb_banyan_trig_ctl;

  logic        adc_clk = 1'b0;
  logic        rst = 1'b1;
  logic        frc = 1'b0;
  logic        arm = 1'b0;
  logic        dis = 1'b0;
  logic        en = 1'b0;
  logic        ext = 1'b0;
  logic [15:0] dly = 16'd0;
  logic        dv = 1'b1;
  logic        roll = 1'b0;
  logic        mem_reset, mem_run, run_s, done;
  logic [1:0]  state;
  logic [15:0] trig_count;

  int n_tests = 0;
  int n_fail  = 0;

  banyan_trig_ctl #(.dw_delay(16), .dw_count(16)) dut (
    .adc_clk       (adc_clk),
    .rst           (rst),
    .force_i       (frc),
    .arm_i         (arm),
    .disarm_i      (dis),
    .ext_trig_en_i (en),
    .ext_trig_i    (ext),
    .trig_delay_i  (dly),
    .data_valid_i  (dv),
    .rollover_i    (roll),
    .mem_reset_o   (mem_reset),
    .mem_run_o     (mem_run),
    .run_s_o       (run_s),
    .state_o       (state),
    .done_o        (done),
    .trig_count_o  (trig_count)
  );

  always #5 adc_clk = ~adc_clk;

  typedef struct {
    logic        frc, arm, dis, en, ext, roll;
    logic [15:0] dly;
    logic [21:0] exp;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic f, a, d, e, x, r, input logic [15:0] dl,
                              input logic [1:0] st, input logic mr, mn, rs, dn,
                              input logic [15:0] cnt);
    vec_t v;
    v.frc = f; v.arm = a; v.dis = d; v.en = e; v.ext = x; v.roll = r; v.dly = dl;
    v.exp = {st, mr, mn, rs, dn, cnt};
    return v;
  endfunction

  function automatic logic [21:0] outs();
    return {state, mem_reset, mem_run, run_s, done, trig_count};
  endfunction

  task automatic tick();
    @(posedge adc_clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    //           frc arm dis en ext roll dly | st mr mn rs dn cnt
    tbl.push_back(mk(0,0,0,0,0,0,0, 0,0,0,0,0,0));
    tbl.push_back(mk(1,0,0,0,0,0,0, 3,1,0,0,0,1));
    tbl.push_back(mk(0,0,0,0,0,0,0, 3,0,1,1,0,1));
    tbl.push_back(mk(0,0,0,0,0,0,0, 3,0,1,1,0,1));
    tbl.push_back(mk(0,0,0,0,0,1,0, 0,0,0,1,1,1));
    tbl.push_back(mk(0,0,0,0,0,0,0, 0,0,0,0,1,1));
    tbl.push_back(mk(0,1,0,0,0,0,0, 3,1,0,0,0,2));
    tbl.push_back(mk(0,0,0,0,0,0,0, 3,0,1,1,0,2));
    tbl.push_back(mk(0,0,0,0,0,1,0, 0,0,0,1,1,2));
    tbl.push_back(mk(0,1,0,1,0,0,0, 1,0,0,0,0,2));
    tbl.push_back(mk(0,0,0,1,1,0,0, 1,0,0,0,0,2));
    tbl.push_back(mk(0,0,0,1,1,0,0, 1,0,0,0,0,2));
    tbl.push_back(mk(0,0,0,1,1,0,0, 3,1,0,0,0,3));
    tbl.push_back(mk(0,0,0,1,1,0,0, 3,0,1,1,0,3));
    tbl.push_back(mk(0,1,0,1,0,0,0, 3,0,1,1,0,3));
    tbl.push_back(mk(0,0,0,0,0,1,0, 0,0,0,1,1,3));
    tbl.push_back(mk(0,0,1,0,0,0,0, 0,0,0,0,1,3));
    tbl.push_back(mk(1,0,1,0,0,0,0, 3,1,0,0,0,4));
    tbl.push_back(mk(0,0,0,0,0,0,0, 3,0,1,1,0,4));
    tbl.push_back(mk(1,0,0,0,0,1,0, 3,1,0,1,0,5));
    tbl.push_back(mk(0,0,0,0,0,0,0, 3,0,1,1,0,5));
    tbl.push_back(mk(0,0,1,0,0,1,0, 0,0,0,1,0,5));
    tbl.push_back(mk(0,0,0,0,0,0,0, 0,0,0,0,0,5));

    // Reset state
    tick(); tick();
    chk("reset_outs", 32'(outs()), 32'h0);
    rst = 1'b0;
    tick();
    chk("post_reset_idle", 32'(outs()), 32'h0);

    foreach (tbl[i]) begin
      frc = tbl[i].frc; arm = tbl[i].arm; dis = tbl[i].dis; en = tbl[i].en;
      ext = tbl[i].ext; roll = tbl[i].roll; dly = tbl[i].dly;
      tick();
      chk($sformatf("vec%0d", i), 32'(outs()), 32'(tbl[i].exp));
    end
    frc = 0; arm = 0; dis = 0; roll = 0; ext = 0; en = 1;

    // Delay 5 with a second ext edge during DELAY and a trig_delay change
    arm = 1; tick(); arm = 0;
    chk("dly_armed", 32'(state), 32'd1);
    ext = 1; dly = 16'd5;
    tick(); tick(); ext = 0;
    tick();
    chk("dly_enter", 32'({state, mem_reset}), 32'({2'd2, 1'b0}));
    dly = 16'd9;
    tick(); ext = 1;
    chk("dly_c3", 32'({state, mem_reset}), 32'({2'd2, 1'b0}));
    tick();
    chk("dly_c4", 32'({state, mem_reset}), 32'({2'd2, 1'b0}));
    tick();
    chk("dly_c5", 32'({state, mem_reset}), 32'({2'd2, 1'b0}));
    tick();
    chk("dly_c6", 32'({state, mem_reset}), 32'({2'd2, 1'b0}));
    tick();
    chk("dly_fire", 32'({state, mem_reset, trig_count}), 32'({2'd3, 1'b1, 16'd6}));
    tick(); tick();
    chk("dly_once", 32'({state, mem_reset, mem_run, trig_count}), 32'({2'd3, 1'b0, 1'b1, 16'd6}));
    dis = 1; tick(); dis = 0; ext = 0;
    chk("dly_disarm", 32'({state, done}), 32'({2'd0, 1'b0}));

    // Disarm coinciding with an ext edge in ARMED
    tick(); tick(); tick();
    arm = 1; tick(); arm = 0;
    chk("dis_armed", 32'(state), 32'd1);
    ext = 1; tick(); tick();
    dis = 1; tick(); dis = 0;
    chk("dis_edge", 32'({state, mem_reset}), 32'({2'd0, 1'b0}));
    tick();
    chk("dis_after", 32'({state, mem_reset, trig_count}), 32'({2'd0, 1'b0, 16'd6}));

    // Asynchronous reset while in DELAY
    ext = 0; tick(); tick(); tick();
    arm = 1; tick(); arm = 0;
    ext = 1; dly = 16'd5;
    tick(); tick(); tick();
    chk("rst_pre_delay", 32'({state, trig_count}), 32'({2'd2, 16'd6}));
    #2 rst = 1'b1;
    #1;
    chk("rst_async", 32'(outs()), 32'h0);
    @(posedge adc_clk); #1 rst = 1'b0; ext = 0;
    tick();
    chk("rst_idle", 32'(outs()), 32'h0);

    // trig_count wrap and run_s stretch
    frc = 1;
    repeat (65535) tick();
    chk("wrap_ffff", 32'({state, trig_count}), 32'({2'd3, 16'hFFFF}));
    tick();
    chk("wrap_zero", 32'({mem_reset, trig_count}), 32'({1'b1, 16'h0000}));
    frc = 0; tick();
    chk("wrap_run", 32'({mem_reset, mem_run, run_s}), 32'({1'b0, 1'b1, 1'b1}));
    dis = 1; tick(); dis = 0;
    chk("runs_stretch", 32'({mem_run, run_s}), 32'({1'b0, 1'b1}));
    tick();
    chk("runs_drop", 32'({mem_run, run_s}), 32'({1'b0, 1'b0}));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
